// File: rtl/issue_scoreboard_if.sv
// Decode/issue/writeback bundle of the issue controller.
// Handshake rule for both decode and issue sides: a transfer happens in a
// cycle where valid and ready are both high at the rising edge; the sender
// keeps valid and its payload stable until that transfer happens.
interface issue_scoreboard_if #(
   parameter int CNT_W = 3
) ();
   // decode side
   logic             i_dec_valid;
   logic             o_dec_ready;
   logic [31:0]      i_dec_pc;
   logic             i_dec_add;
   logic [4:0]       i_dec_rs1_idx;
   logic [4:0]       i_dec_rs2_idx;
   logic [4:0]       i_dec_rd_idx;
   logic             i_dec_rd_wen;
   // issue side
   logic             o_iss_valid;
   logic             i_iss_ready;
   logic [31:0]      o_iss_pc;
   logic             o_iss_add;
   logic [4:0]       o_iss_rs1_idx;
   logic [4:0]       o_iss_rs2_idx;
   logic [4:0]       o_iss_rd_idx;
   logic             o_iss_rd_wen;
   // writeback, flush and status
   logic             i_wb_valid;
   logic [4:0]       i_wb_rd_idx;
   logic             i_flush;
   logic [31:0]      o_busy_vec;
   logic [CNT_W-1:0] o_inflight_cnt;
   logic             o_stall;
   logic             o_wb_err;

   // Pipeline-side driver (decode, execute and writeback stages).
   modport master (
      output i_dec_valid, i_dec_pc, i_dec_add, i_dec_rs1_idx, i_dec_rs2_idx,
             i_dec_rd_idx, i_dec_rd_wen, i_iss_ready, i_wb_valid, i_wb_rd_idx,
             i_flush,
      input  o_dec_ready, o_iss_valid, o_iss_pc, o_iss_add, o_iss_rs1_idx,
             o_iss_rs2_idx, o_iss_rd_idx, o_iss_rd_wen, o_busy_vec,
             o_inflight_cnt, o_stall, o_wb_err
   );

   // Issue controller side.
   modport slave (
      input  i_dec_valid, i_dec_pc, i_dec_add, i_dec_rs1_idx, i_dec_rs2_idx,
             i_dec_rd_idx, i_dec_rd_wen, i_iss_ready, i_wb_valid, i_wb_rd_idx,
             i_flush,
      output o_dec_ready, o_iss_valid, o_iss_pc, o_iss_add, o_iss_rs1_idx,
             o_iss_rs2_idx, o_iss_rd_idx, o_iss_rd_wen, o_busy_vec,
             o_inflight_cnt, o_stall, o_wb_err
   );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller: one-entry issue slot between decode and execute, with a
// 32-entry register scoreboard that blocks RAW/WAW hazards for ADDs and
// caps the number of outstanding register writes.
module issue_scoreboard #(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 3
) (
   input logic               clk,
   input logic               rst_n,
   issue_scoreboard_if.slave sb
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   // issue slot
   logic             hold_valid;
   logic [31:0]      hold_pc;
   logic             hold_add;
   logic [4:0]       hold_rs1;
   logic [4:0]       hold_rs2;
   logic [4:0]       hold_rd;
   logic             hold_rd_wen;

   // scoreboard state
   logic [31:0]      busy_vec;
   logic [CNT_W-1:0] cnt;
   logic             wb_err;

   // combinational control
   logic [31:0]      wb_mask;
   logic [31:0]      eff_busy;
   logic [31:0]      busy_nxt;
   logic [CNT_W-1:0] cnt_eff;
   logic             trk;
   logic             wb_clear;
   logic             hazard;
   logic             limit;
   logic             iss_valid;
   logic             iss_fire;
   logic             dec_ready;
   logic             dec_fire;
   logic             cnt_inc;

   assign wb_mask  = sb.i_wb_valid ? (32'h1 << sb.i_wb_rd_idx) : 32'h0;
   // A writeback this cycle already frees its register for issue this cycle.
   assign eff_busy = busy_vec & ~wb_mask;
   // x0 is never tracked; busy_vec[0] is held at 0 so x0 never clears either.
   assign trk      = hold_rd_wen & (hold_rd != 5'd0);
   assign wb_clear = sb.i_wb_valid & busy_vec[sb.i_wb_rd_idx];
   assign cnt_eff  = cnt - CNT_W'(wb_clear);
   assign limit    = trk & (cnt_eff == MAX_CNT);

   // Operand and destination hazard check, applied to ADDs only.
   always_comb begin
      hazard = 1'b0;
      if (hold_add) begin
         if ((hold_rs1 != 5'd0) && eff_busy[hold_rs1]) hazard = 1'b1;
         if ((hold_rs2 != 5'd0) && eff_busy[hold_rs2]) hazard = 1'b1;
         if (trk && eff_busy[hold_rd])                 hazard = 1'b1;
      end
   end

   assign iss_valid = hold_valid & ~hazard & ~limit & ~sb.i_flush;
   assign iss_fire  = iss_valid & sb.i_iss_ready;
   assign dec_ready = ~hold_valid | iss_fire | sb.i_flush;
   assign dec_fire  = sb.i_dec_valid & dec_ready & ~sb.i_flush;
   assign cnt_inc   = iss_fire & trk;

   // Next scoreboard: clear on writeback, then set on issue so set wins.
   always_comb begin
      busy_nxt = busy_vec;
      if (wb_clear) busy_nxt[sb.i_wb_rd_idx] = 1'b0;
      if (cnt_inc)  busy_nxt[hold_rd]        = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Issue slot: flush empties it, a new decode loads it, an issue drains it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid  <= 1'b0;
         hold_pc     <= 32'h0;
         hold_add    <= 1'b0;
         hold_rs1    <= 5'd0;
         hold_rs2    <= 5'd0;
         hold_rd     <= 5'd0;
         hold_rd_wen <= 1'b0;
      end else if (sb.i_flush) begin
         hold_valid <= 1'b0;
      end else if (dec_fire) begin
         hold_valid  <= 1'b1;
         hold_pc     <= sb.i_dec_pc;
         hold_add    <= sb.i_dec_add;
         hold_rs1    <= sb.i_dec_rs1_idx;
         hold_rs2    <= sb.i_dec_rs2_idx;
         hold_rd     <= sb.i_dec_rd_idx;
         hold_rd_wen <= sb.i_dec_rd_wen;
      end else if (iss_fire) begin
         hold_valid <= 1'b0;
      end
   end

   // Scoreboard, in-flight counter and sticky writeback error; flush leaves
   // these alone because already-issued writes still come back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec <= 32'h0;
         cnt      <= '0;
         wb_err   <= 1'b0;
      end else begin
         busy_vec <= busy_nxt;
         case ({cnt_inc, wb_clear})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
         if (sb.i_wb_valid && !busy_vec[sb.i_wb_rd_idx]) wb_err <= 1'b1;
      end
   end

   assign sb.o_dec_ready    = dec_ready;
   assign sb.o_iss_valid    = iss_valid;
   assign sb.o_iss_pc       = hold_pc;
   assign sb.o_iss_add      = hold_add;
   assign sb.o_iss_rs1_idx  = hold_rs1;
   assign sb.o_iss_rs2_idx  = hold_rs2;
   assign sb.o_iss_rd_idx   = hold_rd;
   assign sb.o_iss_rd_wen   = hold_rd_wen;
   assign sb.o_busy_vec     = busy_vec;
   assign sb.o_inflight_cnt = cnt;
   assign sb.o_stall        = hold_valid & (hazard | limit) & ~sb.i_flush;
   assign sb.o_wb_err       = wb_err;
endmodule
